// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external word-wide memory port between the RC4 decrypt core and the
//   Sobel edge-detect core. Each requester presents {mode, pix_num, wdata}. The arbiter
//   grants one requester (round robin on a tie), adds that requester's base address and
//   drives the memory port until mem_ack_i arrives or the timeout expires. It then
//   returns rdata_o together with a 1-cycle dfb pulse to the granted requester.
//
// Ports
//   clk, n_rst_i                     clock, synchronous active-low reset
//   rc4_mode_i/pix_num_i/wdata_i     RC4 request (mode 01 read, 10 write, else idle)
//   sob_mode_i/pix_num_i/wdata_i     Sobel request, same encoding
//   rc4_dfb_o, sob_dfb_o             1-cycle completion pulses
//   rdata_o                          read data, valid while either dfb is high
//   err_o                            high with dfb when the transaction timed out
//   mem_mode_o/addr_o/wdata_o        memory command, held for the whole BUSY state
//   mem_rdata_i, mem_ack_i           memory read data and completion strobe
//
// Every output is a flop, so no input reaches an output combinationally.
module mem_port_arbiter #(
    parameter logic [19:0] RC4_BASE    = 20'h00000,
    parameter logic [19:0] SOB_BASE    = 20'h80000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        n_rst_i,
    input  logic [1:0]  rc4_mode_i,
    input  logic [19:0] rc4_pix_num_i,
    input  logic [31:0] rc4_wdata_i,
    output logic        rc4_dfb_o,
    input  logic [1:0]  sob_mode_i,
    input  logic [19:0] sob_pix_num_i,
    input  logic [31:0] sob_wdata_i,
    output logic        sob_dfb_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  mem_mode_o,
    output logic [19:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        err_o
);

    localparam logic [1:0] ModeRead  = 2'b01;
    localparam logic [1:0] ModeWrite = 2'b10;
    // Last BUSY cycle before abort; BUSY lasts TIMEOUT_CYC cycles at most.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic        last_grant_q;  // 1: Sobel was granted last
    logic        grant_sob_q;   // requester owning the current transaction
    logic [7:0]  timer_q;

    logic        rc4_valid;
    logic        sob_valid;
    logic        pick_sob;

    always_comb begin
        rc4_valid = (rc4_mode_i == ModeRead) || (rc4_mode_i == ModeWrite);
        sob_valid = (sob_mode_i == ModeRead) || (sob_mode_i == ModeWrite);
        // On a tie, serve whoever was not granted last.
        pick_sob  = sob_valid && (!rc4_valid || !last_grant_q);
    end

    always_ff @(posedge clk) begin
        if (!n_rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_sob_q  <= 1'b0;
            timer_q      <= '0;
            rc4_dfb_o    <= 1'b0;
            sob_dfb_o    <= 1'b0;
            rdata_o      <= '0;
            err_o        <= 1'b0;
            mem_mode_o   <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rc4_valid || sob_valid) begin
                        grant_sob_q  <= pick_sob;
                        last_grant_q <= pick_sob;
                        timer_q      <= '0;
                        state_q      <= StBusy;
                        if (pick_sob) begin
                            mem_mode_o  <= sob_mode_i;
                            mem_addr_o  <= SOB_BASE + sob_pix_num_i;
                            mem_wdata_o <= sob_wdata_i;
                        end else begin
                            mem_mode_o  <= rc4_mode_i;
                            mem_addr_o  <= RC4_BASE + rc4_pix_num_i;
                            mem_wdata_o <= rc4_wdata_i;
                        end
                    end
                end

                StBusy: begin
                    timer_q <= timer_q + 8'd1;
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack_i || (timer_q == TimeoutLast)) begin
                        if (mem_ack_i) begin
                            rdata_o <= (mem_mode_o == ModeRead) ? mem_rdata_i : '0;
                            err_o   <= 1'b0;
                        end else begin
                            rdata_o <= '0;
                            err_o   <= 1'b1;
                        end
                        rc4_dfb_o   <= !grant_sob_q;
                        sob_dfb_o   <= grant_sob_q;
                        mem_mode_o  <= '0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        state_q     <= StDone;
                    end
                end

                StDone: begin
                    rc4_dfb_o <= 1'b0;
                    sob_dfb_o <= 1'b0;
                    err_o     <= 1'b0;
                    state_q   <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        n_rst_i;
    logic [1:0]  rc4_mode_i;
    logic [19:0] rc4_pix_num_i;
    logic [31:0] rc4_wdata_i;
    logic        rc4_dfb_o;
    logic [1:0]  sob_mode_i;
    logic [19:0] sob_pix_num_i;
    logic [31:0] sob_wdata_i;
    logic        sob_dfb_o;
    logic [31:0] rdata_o;
    logic [1:0]  mem_mode_o;
    logic [19:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        err_o;

    mem_port_arbiter #(
        .RC4_BASE   (20'h00000),
        .SOB_BASE   (20'h80000),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk          (clk),
        .n_rst_i      (n_rst_i),
        .rc4_mode_i   (rc4_mode_i),
        .rc4_pix_num_i(rc4_pix_num_i),
        .rc4_wdata_i  (rc4_wdata_i),
        .rc4_dfb_o    (rc4_dfb_o),
        .sob_mode_i   (sob_mode_i),
        .sob_pix_num_i(sob_pix_num_i),
        .sob_wdata_i  (sob_wdata_i),
        .sob_dfb_o    (sob_dfb_o),
        .rdata_o      (rdata_o),
        .mem_mode_o   (mem_mode_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: request fields, memory behaviour and expected results.
    // ack_dly: BUSY cycle (1-based) in which ack is given; 0 means never.
    typedef struct {
        logic        sob;
        logic [1:0]  mode;
        logic [19:0] pix;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] mem_rd;
        logic [19:0] exp_addr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_busy;
    } vec_t;

    vec_t vecs [7];
    vec_t sb [$];
    vec_t rc4_rr;
    vec_t sob_rr;
    vec_t v_rst;

    int n_vec;
    int n_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic drive_req(input vec_t v);
        if (v.sob) begin
            sob_mode_i    = v.mode;
            sob_pix_num_i = v.pix;
            sob_wdata_i   = v.wdata;
        end else begin
            rc4_mode_i    = v.mode;
            rc4_pix_num_i = v.pix;
            rc4_wdata_i   = v.wdata;
        end
    endtask

    task automatic drop_all();
        rc4_mode_i = 2'b00;
        sob_mode_i = 2'b00;
    endtask

    // Memory responder + monitor: compares the port against the scoreboard head while
    // BUSY and pops it on each dfb. gap > 0 also checks dfb spacing.
    task automatic service(input int n_done, input int gap);
        int busy = 0;
        int done = 0;
        int cyc  = 0;
        int last = -1;
        vec_t e;
        while (done < n_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_ack_i = 1'b0;
            if (rc4_dfb_o && sob_dfb_o) flag("both_dfb");
            if (mem_mode_o != 2'b00) begin
                busy++;
                if (sb.size() == 0) begin
                    flag("busy_without_request");
                end else begin
                    check("mem_mode", 32'(mem_mode_o), 32'(sb[0].mode));
                    check("mem_addr", 32'(mem_addr_o), 32'(sb[0].exp_addr));
                    check("mem_wdata", mem_wdata_o, sb[0].wdata);
                    check("err_in_busy", 32'(err_o), 32'd0);
                    mem_rdata_i = sb[0].mem_rd;
                    if (busy == sb[0].ack_dly) mem_ack_i = 1'b1;
                end
            end
            if (rc4_dfb_o || sob_dfb_o) begin
                if (sb.size() == 0) begin
                    flag("dfb_without_request");
                end else begin
                    e = sb.pop_front();
                    check("sob_dfb", 32'(sob_dfb_o), 32'(e.sob));
                    check("rc4_dfb", 32'(rc4_dfb_o), 32'(!e.sob));
                    check("rdata", rdata_o, e.exp_rdata);
                    check("err", 32'(err_o), 32'(e.exp_err));
                    check("busy_cycles", 32'(busy), 32'(e.exp_busy));
                    check("mem_mode_done", 32'(mem_mode_o), 32'd0);
                    if (gap > 0 && last >= 0) check("dfb_gap", 32'(cyc - last), 32'(gap));
                end
                last = cyc;
                busy = 0;
                done++;
                if (done == n_done) drop_all();
            end
        end
        mem_ack_i = 1'b0;
        if (done < n_done) flag("dfb_timeout");
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        //          sob  mode   pix        wdata         ack rd            addr       rdata        err busy
        vecs[0] = '{1'b0, 2'b01, 20'h00005, 32'h0000_0001, 3, 32'hCAFEBABE, 20'h00005, 32'hCAFEBABE, 1'b0, 3};
        vecs[1] = '{1'b0, 2'b01, 20'hFFFFF, 32'h0000_0002, 0, 32'h11112222, 20'hFFFFF, 32'h0,        1'b1, 4};
        vecs[2] = '{1'b1, 2'b10, 20'h7FFFF, 32'h12345678, 1, 32'hDEADBEEF, 20'hFFFFF, 32'h0,        1'b0, 1};
        vecs[3] = '{1'b1, 2'b01, 20'h00010, 32'h0000_0003, 4, 32'hA5A50F0F, 20'h80010, 32'hA5A50F0F, 1'b0, 4};
        vecs[4] = '{1'b0, 2'b10, 20'h00123, 32'h0BADF00D, 2, 32'h55555555, 20'h00123, 32'h0,        1'b0, 2};
        vecs[5] = '{1'b1, 2'b01, 20'h80001, 32'h0000_0004, 1, 32'h13579BDF, 20'h00001, 32'h13579BDF, 1'b0, 1};
        vecs[6] = '{1'b1, 2'b01, 20'h00002, 32'h0000_0005, 0, 32'h77777777, 20'h80002, 32'h0,        1'b1, 4};

        rc4_rr = '{1'b0, 2'b01, 20'h00001, 32'h0, 1, 32'h11111111, 20'h00001, 32'h11111111, 1'b0, 1};
        sob_rr = '{1'b1, 2'b01, 20'h00002, 32'h0, 1, 32'h22222222, 20'h80002, 32'h22222222, 1'b0, 1};

        n_rst_i       = 1'b0;
        rc4_mode_i    = 2'b00;
        rc4_pix_num_i = '0;
        rc4_wdata_i   = '0;
        sob_mode_i    = 2'b00;
        sob_pix_num_i = '0;
        sob_wdata_i   = '0;
        mem_rdata_i   = '0;
        mem_ack_i     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_mode", 32'(mem_mode_o), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_dfb", 32'({rc4_dfb_o, sob_dfb_o, err_o}), 32'd0);
        n_rst_i = 1'b1;
        @(negedge clk);

        // Single-requester vectors.
        for (int i = 0; i < 7; i++) begin
            sb.push_back(vecs[i]);
            drive_req(vecs[i]);
            service(1, 0);
            @(negedge clk);
        end

        // Both requesting continuously: RC4, SOB, RC4, SOB, dfb every 3 cycles.
        sb.push_back(rc4_rr);
        sb.push_back(sob_rr);
        sb.push_back(rc4_rr);
        sb.push_back(sob_rr);
        drive_req(rc4_rr);
        drive_req(sob_rr);
        service(4, 3);
        @(negedge clk);

        // Reset during BUSY with a pending ack; last grant was SOB, make it RC4 first.
        sb.push_back(rc4_rr);
        drive_req(rc4_rr);
        service(1, 0);
        @(negedge clk);
        v_rst = '{1'b0, 2'b01, 20'h00009, 32'h99, 0, 32'h0, 20'h00009, 32'h0, 1'b0, 0};
        drive_req(v_rst);
        @(negedge clk);
        check("pre_rst_mem_mode", 32'(mem_mode_o), 32'd1);
        check("pre_rst_mem_addr", 32'(mem_addr_o), 32'h9);
        @(negedge clk);
        n_rst_i   = 1'b0;
        mem_ack_i = 1'b1;
        @(negedge clk);
        check("midrst_mem_mode", 32'(mem_mode_o), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr_o), 32'd0);
        check("midrst_mem_wdata", mem_wdata_o, 32'd0);
        check("midrst_rdata", rdata_o, 32'd0);
        check("midrst_dfb_err", 32'({rc4_dfb_o, sob_dfb_o, err_o}), 32'd0);
        n_rst_i   = 1'b1;
        mem_ack_i = 1'b0;
        drop_all();
        repeat (2) @(negedge clk);
        check("postrst_dfb_err", 32'({rc4_dfb_o, sob_dfb_o, err_o}), 32'd0);
        check("postrst_mem_mode", 32'(mem_mode_o), 32'd0);

        // First tie after reset goes to RC4.
        sb.push_back(rc4_rr);
        sb.push_back(sob_rr);
        drive_req(rc4_rr);
        drive_req(sob_rr);
        service(2, 3);
        @(negedge clk);

        // Reserved mode and stray acks in IDLE: nothing happens.
        rc4_mode_i    = 2'b11;
        rc4_pix_num_i = 20'h00033;
        sob_mode_i    = 2'b11;
        sob_pix_num_i = 20'h00044;
        mem_ack_i     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mode11_mem_mode", 32'(mem_mode_o), 32'd0);
            check("mode11_mem_addr", 32'(mem_addr_o), 32'd0);
            check("mode11_dfb_err", 32'({rc4_dfb_o, sob_dfb_o, err_o}), 32'd0);
        end
        mem_ack_i = 1'b0;
        drop_all();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
